// File: rtl/uart_irq_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_irq_arbiter
//
// Merges the active-low interrupt requests of NCH UART channels into one
// active-low DSP interrupt. A round-robin arbiter picks the next pending,
// enabled channel. Its channel id and 4-bit ISR are snapshotted into VECTOR,
// and nIRQ_OUT is held low until the DSP writes EOI. An optional hold-off gap
// (HOLDOFF cycles) follows each EOI before the next arbitration can start.
//
// Register map (word address DSP_ADDR = addr[4:1]):
//   4'b1000 MASK    RW  [NCH-1:0]   1 = channel enabled
//   4'b1001 VECTOR  RO  [15] valid, [4+CHW-1:4] channel id, [3:0] ISR snapshot
//   4'b1010 EOI     WO  any write ends the current interrupt; reads 0
//   4'b1011 HOLDOFF RW  [HOLD_W-1:0] gap in cycles after EOI
//
// Ports:
//   DSP_CLK    in   1       clock
//   RESETn     in   1       asynchronous active-low reset
//   DSP_CEn    in   1       chip enable, active low
//   DSP_ADDR   in   4       word address
//   DSP_WDATA  in   32      write data
//   DSP_WEn    in   1       0 = write, 1 = read
//   DSP_RDATA  out  32      {16'd0, registered read data}
//   CH_nIRQ    in   NCH     per-channel interrupt, active low
//   CH_ISR     in   4*NCH   per-channel ISR, channel i at [4i+3:4i]
//   nIRQ_OUT   out  1       merged interrupt to the DSP, active low
// -----------------------------------------------------------------------------
module uart_irq_arbiter #(
  parameter int NCH    = 4,
  parameter int CHW    = 2,
  parameter int HOLD_W = 8
) (
  input  logic             DSP_CLK,
  input  logic             RESETn,
  input  logic             DSP_CEn,
  input  logic [3:0]       DSP_ADDR,
  input  logic [31:0]      DSP_WDATA,
  input  logic             DSP_WEn,
  output logic [31:0]      DSP_RDATA,
  input  logic [NCH-1:0]   CH_nIRQ,
  input  logic [4*NCH-1:0] CH_ISR,
  output logic             nIRQ_OUT
);

  localparam logic [3:0] A_MASK    = 4'b1000;
  localparam logic [3:0] A_VECTOR  = 4'b1001;
  localparam logic [3:0] A_EOI     = 4'b1010;
  localparam logic [3:0] A_HOLDOFF = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARB    = 2'd1,
    S_ASSERT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t              r_state;
  logic [NCH-1:0]      r_mask;
  logic [HOLD_W-1:0]   r_holdoff;
  logic [HOLD_W-1:0]   r_cnt;
  logic [CHW-1:0]      r_last;
  logic [CHW-1:0]      r_vec_ch;
  logic [3:0]          r_vec_isr;
  logic [15:0]         r_rdata;

  logic                w_wr;
  logic                w_rd;
  logic                w_eoi;
  logic [NCH-1:0]      w_pending;
  logic                w_found;
  logic [CHW-1:0]      w_grant;
  logic [CHW-1:0]      w_idx;
  int                  w_t;
  logic [3:0]          w_isr;
  logic [15:0]         w_rdata_nxt;
  logic                w_unused;

  // Bus decode
  assign w_wr  = !DSP_CEn && !DSP_WEn;
  assign w_rd  = !DSP_CEn &&  DSP_WEn;
  assign w_eoi = w_wr && (DSP_ADDR == A_EOI);

  // Write-data bits that no register stores are folded here so the whole bus
  // is visibly consumed.
  assign w_unused = ^DSP_WDATA;

  assign w_pending = ~CH_nIRQ & r_mask;

  // Round robin: walk channels LAST+1, LAST+2, ... wrapping at NCH, and take
  // the first pending one. The wrap is done by subtraction so non-power-of-2
  // channel counts work.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_t     = 0;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_t = int'(r_last) + i;
      if (w_t >= NCH) begin
        w_t = w_t - NCH;
      end
      w_idx = w_t[CHW-1:0];
      if (!w_found && w_pending[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // ISR slice of the channel the arbiter would grant this cycle
  always_comb begin
    w_isr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_grant == CHW'(c)) begin
        w_isr = CH_ISR[4*c +: 4];
      end
    end
  end

  // Read mux; unmapped addresses and unused bits return 0
  always_comb begin
    w_rdata_nxt = '0;
    case (DSP_ADDR)
      A_MASK: begin
        w_rdata_nxt[NCH-1:0] = r_mask;
      end
      A_VECTOR: begin
        w_rdata_nxt[15]        = (r_state == S_ASSERT);
        w_rdata_nxt[4 +: CHW]  = r_vec_ch;
        w_rdata_nxt[3:0]       = r_vec_isr;
      end
      A_HOLDOFF: begin
        w_rdata_nxt[HOLD_W-1:0] = r_holdoff;
      end
      default: begin
        w_rdata_nxt = '0;
      end
    endcase
  end

  // Programmable registers and the registered read port
  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_mask    <= '0;
      r_holdoff <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_wr && (DSP_ADDR == A_MASK)) begin
        r_mask <= DSP_WDATA[NCH-1:0];
      end
      if (w_wr && (DSP_ADDR == A_HOLDOFF)) begin
        r_holdoff <= DSP_WDATA[HOLD_W-1:0];
      end
      if (w_rd) begin
        r_rdata <= w_rdata_nxt;
      end
    end
  end

  // Interrupt FSM. ARB re-evaluates pending so a request that vanished
  // between IDLE and ARB produces no grant. The hold-off counter is loaded
  // only at EOI, so HOLDOFF writes during HOLD leave the running gap alone.
  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= '0;
      r_vec_ch  <= '0;
      r_vec_isr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_pending) begin
            r_state <= S_ARB;
          end
        end
        S_ARB: begin
          if (w_found) begin
            r_last    <= w_grant;
            r_vec_ch  <= w_grant;
            r_vec_isr <= w_isr;
            r_state   <= S_ASSERT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ASSERT: begin
          if (w_eoi) begin
            if (r_holdoff == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_holdoff;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_W'(1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign nIRQ_OUT  = (r_state != S_ASSERT);
  assign DSP_RDATA = {16'd0, r_rdata};

endmodule

// File: tb/tb_uart_irq_arbiter.sv
`timescale 1ns/1ps
// Directed bench for uart_irq_arbiter (NCH=4, CHW=2, HOLD_W=8).
module tb_uart_irq_arbiter;

  localparam logic [3:0] A_MASK    = 4'b1000;
  localparam logic [3:0] A_VECTOR  = 4'b1001;
  localparam logic [3:0] A_EOI     = 4'b1010;
  localparam logic [3:0] A_HOLDOFF = 4'b1011;

  logic        DSP_CLK;
  logic        RESETn;
  logic        DSP_CEn;
  logic [3:0]  DSP_ADDR;
  logic [31:0] DSP_WDATA;
  logic        DSP_WEn;
  logic [31:0] DSP_RDATA;
  logic [3:0]  CH_nIRQ;
  logic [15:0] CH_ISR;
  logic        nIRQ_OUT;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] rdv;
  int          n;
  int          lows;

  uart_irq_arbiter #(.NCH(4), .CHW(2), .HOLD_W(8)) dut (
    .DSP_CLK   (DSP_CLK),
    .RESETn    (RESETn),
    .DSP_CEn   (DSP_CEn),
    .DSP_ADDR  (DSP_ADDR),
    .DSP_WDATA (DSP_WDATA),
    .DSP_WEn   (DSP_WEn),
    .DSP_RDATA (DSP_RDATA),
    .CH_nIRQ   (CH_nIRQ),
    .CH_ISR    (CH_ISR),
    .nIRQ_OUT  (nIRQ_OUT)
  );

  initial DSP_CLK = 1'b0;
  always #5 DSP_CLK = ~DSP_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance k clock edges; return 1 ns after the last edge.
  task automatic step(input int k);
    repeat (k) @(posedge DSP_CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    DSP_CEn = 1'b0; DSP_WEn = 1'b0; DSP_ADDR = a; DSP_WDATA = d;
    step(1);
    DSP_CEn = 1'b1; DSP_WEn = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    DSP_CEn = 1'b0; DSP_WEn = 1'b1; DSP_ADDR = a;
    step(1);
    DSP_CEn = 1'b1;
    d = DSP_RDATA;
  endtask

  task automatic wait_low(input string tag);
    int k;
    k = 0;
    while (nIRQ_OUT && k < 30) begin
      k++;
      step(1);
    end
    chk(tag, {31'd0, nIRQ_OUT}, 32'd0);
  endtask

  initial begin
    RESETn = 1'b0; DSP_CEn = 1'b1; DSP_WEn = 1'b1; DSP_ADDR = 4'd0;
    DSP_WDATA = 32'd0; CH_nIRQ = 4'hF; CH_ISR = 16'h934A;
    step(3);
    RESETn = 1'b1;
    step(1);

    // Reset state
    chk("rst_nirq", {31'd0, nIRQ_OUT}, 32'd1);
    chk("rst_rdata", DSP_RDATA, 32'd0);
    rd(A_MASK, rdv);    chk("rst_mask", rdv, 32'd0);
    rd(A_VECTOR, rdv);  chk("rst_vector", rdv, 32'd0);
    rd(A_HOLDOFF, rdv); chk("rst_holdoff", rdv, 32'd0);
    rd(A_EOI, rdv);     chk("rst_eoi_rd", rdv, 32'd0);

    // Single request on ch1
    wr(A_MASK, 32'hF);
    rd(A_MASK, rdv);    chk("mask_rb", rdv, 32'h0000000F);
    rd(4'b0000, rdv);   chk("unmapped_rd", rdv, 32'd0);
    CH_nIRQ = 4'b1101;
    step(1); chk("ch1_arb_cycle", {31'd0, nIRQ_OUT}, 32'd1);
    step(1); chk("ch1_assert", {31'd0, nIRQ_OUT}, 32'd0);
    rd(A_VECTOR, rdv);  chk("ch1_vector", rdv, 32'h00008014);

    // Granted channel drops and is masked, ISR changes: all ignored until EOI
    CH_ISR = 16'h93FA; CH_nIRQ = 4'hF;
    wr(A_MASK, 32'hD);
    step(3); chk("ch1_hold_low", {31'd0, nIRQ_OUT}, 32'd0);
    rd(A_VECTOR, rdv);  chk("ch1_snapshot", rdv, 32'h00008014);
    CH_ISR = 16'h934A;
    wr(A_MASK, 32'hF);
    wr(A_EOI, 32'hDEAD);
    chk("ch1_eoi_release", {31'd0, nIRQ_OUT}, 32'd1);
    rd(A_VECTOR, rdv);  chk("valid_clear", rdv, 32'h00000014);

    // HOLDOFF=5 on ch3, HOLDOFF rewritten mid-gap
    wr(A_HOLDOFF, 32'd5);
    CH_nIRQ = 4'b0111;
    wait_low("ch3_assert");
    rd(A_VECTOR, rdv);  chk("ch3_vector", rdv, 32'h00008039);
    wr(A_EOI, 32'd0);
    chk("ch3_eoi_release", {31'd0, nIRQ_OUT}, 32'd1);
    wr(A_HOLDOFF, 32'd2);
    n = 1;
    while (nIRQ_OUT && n < 30) begin
      n++;
      step(1);
    end
    chk("hold5_gap", n, 32'd7);
    rd(A_VECTOR, rdv);  chk("ch3_regrant", rdv, 32'h00008039);
    rd(A_HOLDOFF, rdv); chk("holdoff_rb", rdv, 32'd2);

    // ch0 and ch2 alternate with HOLDOFF=0; LAST=3 wraps to ch0 first
    CH_nIRQ = 4'hF;
    wr(A_HOLDOFF, 32'd0);
    wr(A_EOI, 32'd0);
    CH_nIRQ = 4'b1010;
    wait_low("rr_first");
    for (int i = 0; i < 4; i++) begin
      rd(A_VECTOR, rdv);
      chk($sformatf("rr_vec%0d", i), rdv, (i % 2 == 0) ? 32'h0000800A : 32'h00008023);
      wr(A_EOI, 32'd0);
      n = 0;
      while (nIRQ_OUT && n < 30) begin
        n++;
        step(1);
      end
      chk($sformatf("rr_gap%0d", i), n, 32'd2);
    end
    CH_nIRQ = 4'hF;
    wr(A_EOI, 32'd0);

    // Masked request stays quiet, then unmasking raises it
    wr(A_MASK, 32'hE);
    CH_nIRQ = 4'b1110;
    lows = 0;
    repeat (20) begin
      step(1);
      if (!nIRQ_OUT) lows++;
    end
    chk("masked_quiet", lows, 32'd0);
    wr(A_MASK, 32'hF);
    chk("unmask_e0", {31'd0, nIRQ_OUT}, 32'd1);
    step(1); chk("unmask_e1", {31'd0, nIRQ_OUT}, 32'd1);
    step(1); chk("unmask_e2", {31'd0, nIRQ_OUT}, 32'd0);
    rd(A_VECTOR, rdv);  chk("ch0_vector", rdv, 32'h0000800A);

    // Deassert in ASSERT, then EOI in IDLE
    CH_ISR = 16'h9345; CH_nIRQ = 4'hF;
    step(3); chk("ch0_hold_low", {31'd0, nIRQ_OUT}, 32'd0);
    rd(A_VECTOR, rdv);  chk("ch0_snapshot", rdv, 32'h0000800A);
    CH_ISR = 16'h934A;
    wr(A_EOI, 32'd0);
    chk("ch0_eoi_release", {31'd0, nIRQ_OUT}, 32'd1);
    wr(A_EOI, 32'd0);
    chk("eoi_idle_nirq", {31'd0, nIRQ_OUT}, 32'd1);
    rd(A_VECTOR, rdv);  chk("eoi_idle_vector", rdv, 32'h0000000A);

    // MASK cleared on the ARB edge: old MASK still grants ch1
    CH_nIRQ = 4'b1101;
    step(1);
    wr(A_MASK, 32'h0);
    chk("mask_arb_edge", {31'd0, nIRQ_OUT}, 32'd0);
    rd(A_MASK, rdv);    chk("mask_zero_rb", rdv, 32'd0);
    rd(A_VECTOR, rdv);  chk("mask_arb_vector", rdv, 32'h00008014);
    wr(A_MASK, 32'hF);
    rd(A_MASK, rdv);    chk("mask_f_rb", rdv, 32'h0000000F);

    // Asynchronous reset while asserted
    RESETn = 1'b0;
    #1;
    chk("async_rst_nirq", {31'd0, nIRQ_OUT}, 32'd1);
    chk("async_rst_rdata", DSP_RDATA, 32'd0);
    step(2);
    RESETn = 1'b1;
    rd(A_MASK, rdv);    chk("post_rst_mask", rdv, 32'd0);
    rd(A_HOLDOFF, rdv); chk("post_rst_holdoff", rdv, 32'd0);
    rd(A_VECTOR, rdv);  chk("post_rst_vector", rdv, 32'd0);
    chk("post_rst_nirq", {31'd0, nIRQ_OUT}, 32'd1);

    // EOI during HOLD is ignored: gap stays HOLDOFF+2
    wr(A_MASK, 32'hF);
    wr(A_HOLDOFF, 32'd3);
    wait_low("post_rst_grant");
    rd(A_VECTOR, rdv);  chk("post_rst_vec", rdv, 32'h00008014);
    wr(A_EOI, 32'd0);
    chk("hold3_release", {31'd0, nIRQ_OUT}, 32'd1);
    wr(A_EOI, 32'd0);
    n = 1;
    while (nIRQ_OUT && n < 30) begin
      n++;
      step(1);
    end
    chk("hold3_gap", n, 32'd5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
